// File: rtl/user_pulse_capture.sv
// Edge-timestamping monitor for the user-domain pulser bank: captures rising/falling
// edges on up to four pulse lines into a FIFO that software drains over OBI.

package user_pulse_capture_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
        logic        r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

module user_pulse_capture #(
    parameter user_pulse_capture_pkg::obi_cfg_t ObiCfg = user_pulse_capture_pkg::ObiDefaultConfig,
    parameter type obi_req_t = user_pulse_capture_pkg::obi_req_t,
    parameter type obi_rsp_t = user_pulse_capture_pkg::obi_rsp_t,
    parameter int unsigned NumCh     = 4,
    parameter int unsigned FifoDepth = 16,
    parameter int unsigned TsWidth   = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  obi_req_t         obi_req_i,
    output obi_rsp_t         obi_rsp_o,
    input  logic [NumCh-1:0] pulse_i,
    output logic             irq_o
);

    localparam int unsigned DataW = ObiCfg.DataWidth;
    localparam int unsigned IdW   = $bits(obi_req_i.a.aid);
    localparam int unsigned AddrW = $bits(obi_req_i.a.addr);
    localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    localparam logic [4:0] OffCtrl   = 5'h00;
    localparam logic [4:0] OffStatus = 5'h04;
    localparam logic [4:0] OffData   = 5'h08;
    localparam logic [4:0] OffTs     = 5'h0C;

    logic             req_q;
    logic             we_q;
    logic [4:0]       addr_q;
    logic [20:0]      wdata_q;
    logic [IdW-1:0]   id_q;

    logic             enable_q;
    logic [3:0]       rise_en_q;
    logic [3:0]       fall_en_q;
    logic [4:0]       irq_level_q;
    logic [TsWidth-1:0] ts_q;
    logic [3:0]       prev_q;

    logic [31:0]      mem_q [FifoDepth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [4:0]       fill_q;
    logic             overflow_q;
    logic [7:0]       drop_q;
    logic             irq_q;

    logic             ctrl_wr;
    logic             status_wr;
    logic             ts_clear;
    logic             flush;
    logic             ov_clear;
    logic             empty;
    logic             full;
    logic             pop;
    logic [3:0]       pulse_ext;
    logic [3:0]       rise;
    logic [3:0]       fall;
    logic             push;
    logic             push_acc;
    logic             drop_evt;
    logic [31:0]      entry;
    logic [4:0]       fill_d;
    logic [4:0]       irq_level_d;
    logic [DataW-1:0] rdata;

    assign ctrl_wr   = req_q & we_q & (addr_q == OffCtrl);
    assign status_wr = req_q & we_q & (addr_q == OffStatus);
    assign ts_clear  = ctrl_wr & wdata_q[1];
    assign flush     = ctrl_wr & wdata_q[2];
    assign ov_clear  = status_wr & wdata_q[10];

    assign empty = (fill_q == 5'd0);
    assign full  = (fill_q == 5'(FifoDepth));
    assign pop   = req_q & ~we_q & (addr_q == OffData) & ~empty;

    // Unused channel bits are zero in both pulse_ext and prev_q, so they never fire.
    assign pulse_ext = 4'(pulse_i);
    assign rise      = pulse_ext & ~prev_q & rise_en_q & {4{enable_q}};
    assign fall      = ~pulse_ext & prev_q & fall_en_q & {4{enable_q}};
    assign push      = |{rise, fall};
    assign entry     = {rise, fall, ts_q};

    // A pop in the same cycle frees the slot a full FIFO needs; flush discards silently.
    assign push_acc = push & ~flush & (~full | pop);
    assign drop_evt = push & ~flush & full & ~pop;

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = 5'd0;
        end else begin
            fill_d = fill_q + 5'(push_acc) - 5'(pop);
        end
    end

    assign irq_level_d = ctrl_wr ? wdata_q[20:16] : irq_level_q;

    always_comb begin
        rdata = '0;
        if (req_q && !we_q) begin
            case (addr_q)
                OffCtrl:   rdata = {11'b0, irq_level_q, 4'b0, fall_en_q, rise_en_q, 3'b0, enable_q};
                OffStatus: rdata = {8'b0, drop_q, 5'b0, overflow_q, full, empty, 3'b0, fill_q};
                OffData:   rdata = empty ? 32'h0 : mem_q[rptr_q];
                OffTs:     rdata = 32'(ts_q);
                default:   rdata = 32'hDEAD_BEEF;
            endcase
        end
    end

    always_comb begin
        obi_rsp_o              = '0;
        obi_rsp_o.gnt          = obi_req_i.req;
        obi_rsp_o.rvalid       = req_q;
        obi_rsp_o.r.rid        = id_q;
        obi_rsp_o.r.rdata      = rdata;
    end

    assign irq_o = irq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            id_q        <= '0;
            enable_q    <= 1'b0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            irq_level_q <= '0;
            ts_q        <= '0;
            prev_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fill_q      <= '0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
            irq_q       <= 1'b0;
        end else begin
            req_q <= obi_req_i.req;
            if (obi_req_i.req) begin
                we_q    <= obi_req_i.a.we;
                addr_q  <= obi_req_i.a.addr[4:0];
                wdata_q <= obi_req_i.a.wdata[20:0];
                id_q    <= obi_req_i.a.aid;
            end

            prev_q <= pulse_ext;

            if (ctrl_wr) begin
                enable_q    <= wdata_q[0];
                rise_en_q   <= wdata_q[7:4];
                fall_en_q   <= wdata_q[11:8];
                irq_level_q <= wdata_q[20:16];
            end

            if (ts_clear) begin
                ts_q <= '0;
            end else if (enable_q) begin
                ts_q <= ts_q + TsWidth'(1);
            end

            if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push_acc) wptr_q <= wptr_q + PtrW'(1);
                if (pop)      rptr_q <= rptr_q + PtrW'(1);
            end
            fill_q <= fill_d;

            // A drop landing in the same cycle as the clear is still accounted for.
            if (ov_clear) begin
                overflow_q <= drop_evt;
                drop_q     <= drop_evt ? 8'd1 : 8'd0;
            end else if (drop_evt) begin
                overflow_q <= 1'b1;
                if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            end

            irq_q <= (irq_level_d != 5'd0) && (fill_d >= irq_level_d);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FifoDepth); i++) mem_q[i] <= '0;
        end else if (push_acc) begin
            mem_q[wptr_q] <= entry;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{obi_req_i.a.addr[AddrW-1:5], obi_req_i.a.be,
                           obi_req_i.a.wdata[31:21], wdata_q[3], wdata_q[15:12]};

endmodule

// File: tb/tb_user_pulse_capture.sv
// Directed bench for user_pulse_capture: register table plus hand-written
// sequences for FIFO full/overflow, irq threshold and mid-run reset.

module tb_user_pulse_capture;
    import user_pulse_capture_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    obi_req_t   obi_req;
    obi_rsp_t   obi_rsp;
    logic [3:0] pulse_i;
    logic       irq_o;

    int total = 0;
    int bad   = 0;
    logic [3:0] aid_cnt = 4'd0;

    typedef struct {
        logic [3:0]  pulse;
        int          idle;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 15;

    always #5 clk_i = ~clk_i;

    user_pulse_capture dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .obi_req_i (obi_req),
        .obi_rsp_o (obi_rsp),
        .pulse_i   (pulse_i),
        .irq_o     (irq_o)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Request in one cycle, sample the response in the next; p_rsp changes pulse_i in the response cycle.
    task automatic obiAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] p_req, input logic [3:0] p_rsp,
                             output logic [31:0] rdata);
        @(negedge clk_i);
        pulse_i           = p_req;
        obi_req.req       = 1'b1;
        obi_req.a.addr    = addr;
        obi_req.a.we      = we;
        obi_req.a.be      = 4'hF;
        obi_req.a.wdata   = wdata;
        obi_req.a.aid     = aid_cnt;
        @(negedge clk_i);
        rdata = obi_rsp.r.rdata;
        checkOutput("rsp_hdr", {27'b0, obi_rsp.rvalid, obi_rsp.r.rid}, {27'b0, 1'b1, aid_cnt});
        obi_req = '0;
        pulse_i = p_rsp;
        aid_cnt++;
    endtask

    task automatic applyStimulus(input vec_t v, output logic [31:0] rdata);
        repeat (v.idle) @(negedge clk_i);
        obiAccess(v.we, v.addr, v.wdata, v.pulse, v.pulse, rdata);
    endtask

    task automatic rdCheck(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        obiAccess(1'b0, addr, 32'h0, pulse_i, pulse_i, d);
        checkOutput(name, d, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        obiAccess(1'b1, addr, data, pulse_i, pulse_i, d);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t        vecs [NV];
        logic [31:0] d;
        logic [31:0] exp_q [$];

        // Register-level vectors; the timestamp values follow from the fixed access pacing.
        vecs[0]  = '{4'h4, 0,  1'b0, 32'h00, 32'h0,   1'b1, 32'h0000_0000};
        vecs[1]  = '{4'h4, 0,  1'b0, 32'h04, 32'h0,   1'b1, 32'h0000_0100};
        vecs[2]  = '{4'h4, 0,  1'b0, 32'h0C, 32'h0,   1'b1, 32'h0000_0000};
        vecs[3]  = '{4'h4, 0,  1'b0, 32'h10, 32'h0,   1'b1, 32'hDEAD_BEEF};
        vecs[4]  = '{4'h4, 0,  1'b0, 32'h08, 32'h0,   1'b1, 32'h0000_0000};
        vecs[5]  = '{4'h4, 0,  1'b1, 32'h00, 32'hFF3, 1'b0, 32'h0};
        vecs[6]  = '{4'h4, 0,  1'b0, 32'h00, 32'h0,   1'b1, 32'h0000_0FF1};
        vecs[7]  = '{4'h4, 0,  1'b0, 32'h0C, 32'h0,   1'b1, 32'h0000_0003};
        vecs[8]  = '{4'h2, 1,  1'b0, 32'h04, 32'h0,   1'b1, 32'h0000_0001};
        vecs[9]  = '{4'h2, 0,  1'b0, 32'h08, 32'h0,   1'b1, 32'h2400_0005};
        vecs[10] = '{4'h2, 0,  1'b0, 32'h04, 32'h0,   1'b1, 32'h0000_0100};
        vecs[11] = '{4'h2, 0,  1'b1, 32'h00, 32'h13,  1'b0, 32'h0};
        vecs[12] = '{4'h3, 10, 1'b0, 32'h04, 32'h0,   1'b1, 32'h0000_0001};
        vecs[13] = '{4'h0, 0,  1'b0, 32'h08, 32'h0,   1'b1, 32'h1000_000A};
        vecs[14] = '{4'h0, 0,  1'b0, 32'h04, 32'h0,   1'b1, 32'h0000_0100};

        obi_req = '0;
        pulse_i = 4'h0;
        rst_ni  = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("reset_irq", {31'b0, irq_o}, 32'h0);
        checkOutput("reset_rvalid", {31'b0, obi_rsp.rvalid}, 32'h0);
        rst_ni = 1'b1;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i], d);
            if (vecs[i].chk) checkOutput($sformatf("vec%0d", i), d, vecs[i].exp);
        end

        // Fill the FIFO with one ch0 edge per cycle, then three more edges that must be dropped.
        wr(32'h00, 32'hFF3);
        for (int j = 0; j < 19; j++) begin
            @(negedge clk_i);
            pulse_i[0] = ~pulse_i[0];
            if (j < 16) exp_q.push_back(((j % 2) == 0) ? (32'h1000_0000 | j) : (32'h0100_0000 | j));
        end
        rdCheck("full_status", 32'h04, 32'h0003_0610);

        // Falls off; a rise landing in the DATA read response cycle replaces the popped slot.
        wr(32'h00, 32'h0F1);
        obiAccess(1'b0, 32'h08, 32'h0, 4'h0, 4'h1, d);
        checkOutput("pop_push_data", d, exp_q.pop_front());
        exp_q.push_back(32'h1000_0018);
        rdCheck("pop_push_status", 32'h04, 32'h0003_0610);

        for (int j = 0; j < 16; j++) begin
            obiAccess(1'b0, 32'h08, 32'h0, pulse_i, pulse_i, d);
            checkOutput($sformatf("drain%0d", j), d, exp_q.pop_front());
        end
        rdCheck("drain_empty_data", 32'h08, 32'h0);
        rdCheck("drain_status", 32'h04, 32'h0003_0500);
        wr(32'h04, 32'h400);
        rdCheck("ovf_clear", 32'h04, 32'h0000_0100);

        // irq threshold of 4 with ch0 edges in both directions enabled.
        wr(32'h00, 32'h0004_0111);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            checkOutput($sformatf("irq_low%0d", k), {31'b0, irq_o}, 32'h0);
            pulse_i[0] = ~pulse_i[0];
        end
        @(negedge clk_i);
        checkOutput("irq_rise", {31'b0, irq_o}, 32'h1);
        obiAccess(1'b0, 32'h08, 32'h0, pulse_i, pulse_i, d);
        checkOutput("irq_hold_in_pop", {31'b0, irq_o}, 32'h1);
        @(negedge clk_i);
        checkOutput("irq_fall", {31'b0, irq_o}, 32'h0);
        rdCheck("irq_fill3", 32'h04, 32'h0000_0003);

        // Reach fill 5, then reset mid-operation.
        repeat (2) begin
            @(negedge clk_i);
            pulse_i[0] = ~pulse_i[0];
        end
        rdCheck("pre_reset_fill", 32'h04, 32'h0000_0005);
        checkOutput("pre_reset_irq", {31'b0, irq_o}, 32'h1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("in_reset_irq", {31'b0, irq_o}, 32'h0);
        rst_ni = 1'b1;
        rdCheck("post_reset_status", 32'h04, 32'h0000_0100);
        rdCheck("post_reset_ts", 32'h0C, 32'h0);
        rdCheck("post_reset_ctrl", 32'h00, 32'h0);
        repeat (2) begin
            @(negedge clk_i);
            pulse_i[0] = ~pulse_i[0];
        end
        rdCheck("disabled_no_capture", 32'h04, 32'h0000_0100);

        wr(32'h00, 32'h11);
        repeat (2) begin
            @(negedge clk_i);
            pulse_i[0] = ~pulse_i[0];
        end
        rdCheck("reenabled_capture", 32'h04, 32'h0000_0001);
        wr(32'h00, 32'h15);
        rdCheck("flush_status", 32'h04, 32'h0000_0100);
        rdCheck("flush_ctrl", 32'h00, 32'h0000_0011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/user_pulse_capture.md
Name: user_pulse_capture

Overview:
- Downstream monitor for the user-domain pulser bank. Watches up to four pulse lines, detects rising and falling edges, and timestamps each detection with a free-running counter.
- Event records go into a FIFO that software drains over the OBI subordinate port. Status, drop accounting and a fill-level interrupt are also provided over OBI.
- Sits beside the pulser wrapper on the user-domain OBI crossbar. pulse_i is driven directly by the pulser outputs in the same clock domain.

Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration; DataWidth must be 32.
- obi_req_t, logic, OBI request struct type.
- obi_rsp_t, logic, OBI response struct type.
- NumCh, 4, number of monitored channels; range 1..4.
- FifoDepth, 16, number of event entries; power of two, 2..16.
- TsWidth, 24, timestamp counter width; fixed at 24 in the entry format.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- obi_req_i  in  obi_req_t  OBI request.
- obi_rsp_o  out  obi_rsp_t  OBI response.
- pulse_i  in  NumCh  pulse lines, synchronous to clk_i.
- irq_o  out  1  level interrupt, fill level at or above threshold.

Behaviour:
- Reset: all registers are 0. irq_o=0, FIFO empty, ts=0, drop=0, overflow=0, prev_q=0, obi_rsp_o all zero.
- OBI protocol:
  - gnt=req, combinational.
  - Address, we, wdata and aid are registered. rvalid=req_q one cycle later, rid=id_q, r_optional=0, err=0 always.
  - Register offset is addr_q[4:0].
  - Writes take effect at the end of the response cycle T.
- Register map:
  - 0x00 CTRL (RW):
    - [0] enable.
    - [1] ts_clear, write-1 pulse, reads 0.
    - [2] flush, write-1 pulse, reads 0.
    - [7:4] rise_en.
    - [11:8] fall_en.
    - [20:16] irq_level.
  - 0x04 STATUS (RO):
    - [4:0] fill.
    - [8] empty.
    - [9] full.
    - [10] overflow (sticky).
    - [23:16] drop count.
    - A write with wdata[10]=1 clears both overflow and drop; other write bits are ignored.
  - 0x08 DATA (RO): returns the head entry and pops it in the response cycle. If the FIFO is empty it returns 0 and does not pop.
  - 0x0C TS (RO): returns the current counter value, zero-extended.
  - Other offsets: reads return 32'hDEADBEEF; writes are ignored.
- Timestamp counter:
  - Increments by 1 every cycle while enable=1, wrapping modulo 2^24. It holds while enable=0.
  - ts_clear sets the counter to 0 in cycle T+1; it then counts from T+1. An event detected in cycle T+1+k records k.
- Edge detection:
  - prev_q <= pulse_i every cycle, regardless of enable, so enabling never produces a spurious edge.
  - rise[i] = pulse_i[i] & ~prev_q[i] & rise_en[i] & enable.
  - fall[i] = ~pulse_i[i] & prev_q[i] & fall_en[i] & enable.
- Event entry: {rise[3:0], fall[3:0], ts[23:0]}.
  - The timestamp is the counter value in the detection cycle.
  - All channels' edges in one cycle form a single entry, so at most one push per cycle. Unused channel bits are 0.
- Push rules:
  - Push occurs when any rise or fall bit is set.
  - It is accepted if the FIFO is not full, or if a DATA pop occurs in the same cycle.
  - Otherwise the event is dropped: overflow=1 and drop increments, saturating at 255.
- Push and pop in the same cycle:
  - FIFO empty: the read returns 0 and the new entry is stored.
  - FIFO non-empty: fill is unchanged.
- Flush:
  - In cycle T, empties the FIFO.
  - A push in the same cycle is discarded and is not counted as a drop.
  - A DATA read in flight in the same cycle still returns the old head.
- irq_o: registered, equal to (irq_level!=0) & (fill >= irq_level), evaluated on the next-state fill.
- Order: entries are read strictly FIFO. Pointers wrap modulo FifoDepth.
- Reset mid-operation: returns immediately to the reset state. FIFO contents are discarded and pending OBI responses are lost.

Test Plan:
- CTRL write 0x0000_0013 (enable, ts_clear, rise_en ch0); pulse_i[0] rises in cycle T+11 -> DATA read returns 0x1000_000A and STATUS.empty=1 afterwards.
- rise_en=0xF, fall_en=0xF; pulse_i goes from 0x4 to 0x2 in one cycle at ts=5 -> single entry 0x2400_0005, fill=1.
- Push 16 entries, then 3 more edges -> STATUS full=1, overflow=1, drop=3. Then 16 DATA reads return entries in order; the 17th returns 0. STATUS write 0x400 clears overflow and drop.
- FIFO full, DATA read response cycle coincides with a rise -> entry accepted, fill stays 16, drop unchanged.
- irq_level=4 -> irq_o=0 at fill 3, rises one cycle after the 4th push, falls one cycle after the pop to 3.
- Fill 5 entries, toggle rst_ni low for 2 cycles -> fill=0, ts=0, CTRL=0, irq_o=0. Edges after release are not captured until enable is rewritten.
